lpddr5_traffic_gen: RTL and testbench

Parametrised, synthesizable traffic generator and self-checker that drives the lpddr5_controller host command port. It issues a programmable sequence of burst writes and read-backs, compares returned data against the same deterministic pattern, and reports pass/fail and error details. It sits in place of host stimulus in block and system benches, and in silicon bring-up wrappers in front of lpddr5_controller.

---
 rtl/lpddr5_traffic_gen.sv | 229 ++++++++++++++++++++++
 tb/tb_lpddr5_traffic_gen.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpddr5_traffic_gen.sv
// lpddr5_traffic_gen: programmable write/read-back traffic generator and self-checker that
// drives the lpddr5_controller host command port.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, mode, seed run request (IDLE only); 0 = SEQ, 1 = INTLV; pattern seed
//   busy, done, pass  run status; done is sticky until the next accepted start
//   err_count         miscompares plus timeouts, saturating
//   first_err_addr    address of the first failing read
//   timeout_seen      sticky, at least one read timed out
//   cmd_*             host command port (valid/ready handshake, read strobe)
//
// Every output is decoded from registered state only; cmd_ready and cmd_rdata feed next-state
// logic only.
module lpddr5_traffic_gen #(
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter int unsigned            DATA_BITS      = 32,
  parameter int unsigned            BURST_LENGTH   = 16,
  parameter int unsigned            PRIORITY_WIDTH = 2,
  parameter int unsigned            NUM_TXN        = 16,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = 'h1000,
  parameter logic [ADDR_WIDTH-1:0]  ADDR_STRIDE    = 'h40,
  parameter int unsigned            RD_PRIORITY    = 1,
  parameter int unsigned            TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              mode,
  input  logic [DATA_BITS-1:0]              seed,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [15:0]                       err_count,
  output logic [ADDR_WIDTH-1:0]             first_err_addr,
  output logic                              timeout_seen,
  output logic                              cmd_valid,
  output logic                              cmd_rw,
  output logic [PRIORITY_WIDTH-1:0]         cmd_priority,
  output logic [ADDR_WIDTH-1:0]             cmd_addr,
  output logic [DATA_BITS*BURST_LENGTH-1:0] cmd_wdata,
  input  logic                              cmd_ready,
  input  logic [DATA_BITS*BURST_LENGTH-1:0] cmd_rdata,
  input  logic                              cmd_rdata_valid
);

  localparam int unsigned IdxW = $clog2(NUM_TXN + 1);
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BusW = DATA_BITS * BURST_LENGTH;

  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_TXN - 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StWrReq, StRdReq, StRdWait, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [DATA_BITS-1:0]    seed_q, seed_d;
  logic [IdxW-1:0]         wr_idx_q, wr_idx_d;
  logic [IdxW-1:0]         rd_idx_q, rd_idx_d;
  logic [TmrW-1:0]         timer_q, timer_d;
  logic [15:0]             err_q, err_d;
  logic [ADDR_WIDTH-1:0]   first_q, first_d;
  logic                    tos_q, tos_d;
  logic                    done_q, done_d;

  // Address of transaction idx, wrapping modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] txn_addr(input logic [IdxW-1:0] idx);
    return BASE_ADDR + ADDR_WIDTH'(idx) * ADDR_STRIDE;
  endfunction

  // Beat b of transaction idx is seed + idx*BURST_LENGTH + b, modulo 2^DATA_BITS.
  function automatic logic [BusW-1:0] txn_pattern(input logic [DATA_BITS-1:0] s,
                                                  input logic [IdxW-1:0]      idx);
    logic [BusW-1:0]      pat;
    logic [DATA_BITS-1:0] base;
    pat  = '0;
    base = s + DATA_BITS'(idx) * DATA_BITS'(BURST_LENGTH);
    for (int unsigned b = 0; b < BURST_LENGTH; b++) begin
      pat[b*DATA_BITS +: DATA_BITS] = base + DATA_BITS'(b);
    end
    return pat;
  endfunction

  logic            read_end;
  logic            read_failed;
  logic [BusW-1:0] rd_expect;

  assign rd_expect = txn_pattern(seed_q, rd_idx_q);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    timer_d     = timer_q;
    err_d       = err_q;
    first_d     = first_q;
    tos_d       = tos_q;
    done_d      = done_q;
    read_end    = 1'b0;
    read_failed = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d   = mode;
          seed_d   = seed;
          err_d    = '0;
          first_d  = '0;
          tos_d    = 1'b0;
          done_d   = 1'b0;
          wr_idx_d = '0;
          rd_idx_d = '0;
          state_d  = StWrReq;
        end
      end
      StWrReq: begin
        if (cmd_ready) begin
          wr_idx_d = wr_idx_q + 1'b1;
          if (mode_q || (wr_idx_q == IdxLast)) begin
            state_d = StRdReq;
          end
        end
      end
      StRdReq: begin
        if (cmd_ready) begin
          timer_d = '0;
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        // A strobe in the last timer cycle still counts as a response, not a timeout.
        if (cmd_rdata_valid) begin
          read_end    = 1'b1;
          read_failed = (cmd_rdata != rd_expect);
        end else if (timer_q == TmrLast) begin
          read_end    = 1'b1;
          read_failed = 1'b1;
          tos_d       = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end

        if (read_end) begin
          if (read_failed) begin
            err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
            if (err_q == '0) begin
              first_d = txn_addr(rd_idx_q);
            end
          end
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_idx_q == IdxLast) begin
            // done is raised on DONE entry so it is visible in the first DONE cycle.
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            state_d = mode_q ? StWrReq : StRdReq;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      mode_q   <= 1'b0;
      seed_q   <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      timer_q  <= '0;
      err_q    <= '0;
      first_q  <= '0;
      tos_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      seed_q   <= seed_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      first_q  <= first_d;
      tos_q    <= tos_d;
      done_q   <= done_d;
    end
  end

  // Command payload depends only on state and indices, so it is stable while stalled.
  always_comb begin
    cmd_valid    = 1'b0;
    cmd_rw       = 1'b0;
    cmd_priority = '0;
    cmd_addr     = '0;
    cmd_wdata    = '0;
    unique case (state_q)
      StWrReq: begin
        cmd_valid = 1'b1;
        cmd_rw    = 1'b1;
        cmd_addr  = txn_addr(wr_idx_q);
        cmd_wdata = txn_pattern(seed_q, wr_idx_q);
      end
      StRdReq: begin
        cmd_valid    = 1'b1;
        cmd_priority = PRIORITY_WIDTH'(RD_PRIORITY);
        cmd_addr     = txn_addr(rd_idx_q);
      end
      default: begin
      end
    endcase
  end

  assign busy           = (state_q == StWrReq) || (state_q == StRdReq) || (state_q == StRdWait);
  assign done           = done_q;
  assign pass           = done_q && (err_q == '0);
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign timeout_seen   = tos_q;

endmodule

// File: tb/tb_lpddr5_traffic_gen.sv
// Self-checking bench for lpddr5_traffic_gen: an echo memory answers reads one cycle after
// acceptance (with optional corruption, dropped reads and write stalls), and a command model
// built from the address/pattern rules is compared against every presented command.
module tb_lpddr5_traffic_gen;

  localparam int          NT     = 4;
  localparam int          TO     = 16;
  localparam int          DB     = 32;
  localparam int          BL     = 16;
  localparam logic [31:0] BASE   = 32'h1000;
  localparam logic [31:0] STRIDE = 32'h40;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [31:0]  seed = '0;
  logic         busy, done, pass, timeout_seen;
  logic [15:0]  err_count;
  logic [31:0]  first_err_addr;
  logic         cmd_valid, cmd_rw;
  logic [1:0]   cmd_priority;
  logic [31:0]  cmd_addr;
  logic [511:0] cmd_wdata;
  logic         cmd_ready = 1'b1;
  logic [511:0] cmd_rdata = '0;
  logic         cmd_rdata_valid = 1'b0;

  always #5 clk = ~clk;

  lpddr5_traffic_gen #(
    .NUM_TXN        (NT),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .mode            (mode),
    .seed            (seed),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_addr  (first_err_addr),
    .timeout_seen    (timeout_seen),
    .cmd_valid       (cmd_valid),
    .cmd_rw          (cmd_rw),
    .cmd_priority    (cmd_priority),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .cmd_ready       (cmd_ready),
    .cmd_rdata       (cmd_rdata),
    .cmd_rdata_valid (cmd_rdata_valid)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  // ---------------- model ----------------
  function automatic logic [31:0] m_addr(input int i);
    return BASE + 32'(i) * STRIDE;
  endfunction

  function automatic logic [511:0] m_pat(input logic [31:0] s, input int i);
    logic [511:0] r;
    for (int b = 0; b < BL; b++) r[b*DB +: DB] = s + 32'(i * BL + b);
    return r;
  endfunction

  bit           exp_rw   [2*NT];
  logic [31:0]  exp_addr [2*NT];
  logic [511:0] exp_wd   [2*NT];
  logic [1:0]   exp_pr   [2*NT];
  int           exp_n;
  int           cmd_ptr;

  task automatic add_cmd(input bit rw, input int i, input logic [31:0] s);
    exp_rw[exp_n]   = rw;
    exp_addr[exp_n] = m_addr(i);
    exp_wd[exp_n]   = rw ? m_pat(s, i) : '0;
    exp_pr[exp_n]   = rw ? 2'd0 : 2'd1;
    exp_n++;
  endtask

  // Echo memory and fault configuration.
  logic [511:0] mem [logic [31:0]];
  int           corrupt_txn = -1;
  int           drop_txn    = -1;
  bit           stall_en    = 1'b0;
  int           stall_cnt   = 0;
  logic [31:0]  seen_waddr [$];
  logic [31:0]  seen_w1_beat0;

  task automatic build_model(input bit m, input logic [31:0] s);
    exp_n = 0;
    mem.delete();
    seen_waddr.delete();
    if (!m) begin
      for (int i = 0; i < NT; i++) add_cmd(1'b1, i, s);
      for (int i = 0; i < NT; i++) add_cmd(1'b0, i, s);
    end else begin
      for (int i = 0; i < NT; i++) begin
        add_cmd(1'b1, i, s);
        add_cmd(1'b0, i, s);
      end
    end
  endtask

  // Responder: observe acceptance before the edge, answer reads in the following cycle.
  initial begin
    bit           acc_rd;
    logic [31:0]  rd_addr;
    logic [511:0] d;
    int           t;
    forever begin
      @(negedge clk);
      acc_rd = 1'b0;
      if (cmd_valid && cmd_ready) begin
        if (cmd_rw) mem[cmd_addr] = cmd_wdata;
        else begin
          acc_rd  = 1'b1;
          rd_addr = cmd_addr;
        end
      end
      @(posedge clk);
      #1;
      cmd_rdata_valid = 1'b0;
      cmd_rdata       = '0;
      if (acc_rd) begin
        t = int'((rd_addr - BASE) / STRIDE);
        if (t != drop_txn) begin
          d = mem.exists(rd_addr) ? mem[rd_addr] : '0;
          if (t == corrupt_txn) d[5*DB] = ~d[5*DB];
          cmd_rdata       = d;
          cmd_rdata_valid = 1'b1;
        end
      end
      if (stall_en && cmd_valid && cmd_rw && cmd_addr == m_addr(2) && stall_cnt < 7) begin
        cmd_ready = 1'b0;
        stall_cnt++;
      end else begin
        cmd_ready = 1'b1;
      end
    end
  end

  // Compare process: every presented command must match the next model entry.
  bit chk_en     = 1'b0;
  bit prev_stall = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("busy_vs_done", busy, !done);
        if (prev_stall) chk("valid_held", cmd_valid, 1'b1);
        if (cmd_valid) begin
          if (cmd_ptr < exp_n) begin
            chk("cmd_rw", cmd_rw, exp_rw[cmd_ptr]);
            chk("cmd_addr", cmd_addr, exp_addr[cmd_ptr]);
            chk("cmd_priority", cmd_priority, exp_pr[cmd_ptr]);
            chk("cmd_wdata", cmd_wdata, exp_wd[cmd_ptr]);
          end else begin
            chk("cmd_index", cmd_ptr + 1, exp_n);
          end
          if (cmd_ready) begin
            if (cmd_rw) seen_waddr.push_back(cmd_addr);
            if (cmd_rw && cmd_addr == 32'h1040) seen_w1_beat0 = cmd_wdata[31:0];
            cmd_ptr++;
          end
        end
        prev_stall = cmd_valid && !cmd_ready;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic pulse_start(input bit m, input logic [31:0] s);
    build_model(m, s);
    cmd_ptr   = 0;
    stall_cnt = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    mode  = m;
    seed  = s;
    @(posedge clk);  // edge 0
    #1;
    start  = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic run_test(input string name, input bit m, input logic [31:0] s,
                          input int exp_cycles);
    int          n;
    bit          got;
    int          exp_err;
    logic [31:0] exp_first;
    int          first_i;
    exp_err = 0;
    first_i = NT;
    if (corrupt_txn >= 0) begin
      exp_err++;
      if (corrupt_txn < first_i) first_i = corrupt_txn;
    end
    if (drop_txn >= 0 && drop_txn != corrupt_txn) begin
      exp_err++;
      if (drop_txn < first_i) first_i = drop_txn;
    end
    exp_first = (exp_err > 0) ? m_addr(first_i) : 32'h0;

    pulse_start(m, s);
    n   = 0;
    got = 1'b0;
    while (n < 200 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({name, "_busy_c1"}, busy, 1'b1);
      if (done) got = 1'b1;
    end
    chk({name, "_done_cycle"}, n, exp_cycles);
    chk({name, "_pass"}, pass, exp_err == 0);
    chk({name, "_err_count"}, err_count, exp_err);
    chk({name, "_first_err_addr"}, first_err_addr, exp_first);
    chk({name, "_timeout_seen"}, timeout_seen, drop_txn >= 0);
    chk({name, "_cmd_total"}, cmd_ptr, exp_n);
    chk({name, "_busy_end"}, busy, 1'b0);
    chk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    // Reset values while rst is high.
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_err_count", err_count, 16'h0);
    chk("rst_cmd_wdata", cmd_wdata, 512'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // SEQ, ideal memory.
    run_test("seq", 1'b0, 32'hDEADBEEF, 13);
    chk("seq_waddr0", seen_waddr.size() > 0 ? seen_waddr[0] : 32'hX, 32'h1000);
    chk("seq_waddr1", seen_waddr.size() > 1 ? seen_waddr[1] : 32'hX, 32'h1040);
    chk("seq_waddr2", seen_waddr.size() > 2 ? seen_waddr[2] : 32'hX, 32'h1080);
    chk("seq_waddr3", seen_waddr.size() > 3 ? seen_waddr[3] : 32'hX, 32'h10C0);
    chk("seq_txn1_beat0", seen_w1_beat0, 32'hDEADBEFF);

    // INTLV, ideal memory.
    run_test("intlv", 1'b1, 32'hDEADBEEF, 13);

    // Bit 0 of beat 5 flipped on transaction 2.
    corrupt_txn = 2;
    run_test("corrupt", 1'b0, 32'hDEADBEEF, 13);
    corrupt_txn = -1;

    // Write 2 stalled for 7 cycles.
    stall_en = 1'b1;
    run_test("stall", 1'b0, 32'h12345678, 20);
    stall_en = 1'b0;

    // Read 3 never answered.
    drop_txn = 3;
    run_test("timeout", 1'b0, 32'hCAFEF00D, 28);
    drop_txn = -1;

    // Stray start mid-run, then asynchronous reset during RD_WAIT.
    pulse_start(1'b1, 32'h0BADF00D);  // cycle 1
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;  // sampled at edge 3, DUT in RD_WAIT
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;  // cycle 6: read 1 outstanding
    chk("rstmid_busy_before", busy, 1'b1);
    chk("rstmid_cmds_before", cmd_ptr, 4);
    chk("rstmid_in_wait", cmd_valid, 1'b0);
    chk_en = 1'b0;
    rst    = 1'b1;
    start  = 1'b1;
    #1;
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_done", done, 1'b0);
    chk("rstmid_cmd_valid", cmd_valid, 1'b0);
    chk("rstmid_err_count", err_count, 16'h0);
    chk("rstmid_first_err_addr", first_err_addr, 32'h0);
    chk("rstmid_timeout_seen", timeout_seen, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b0;
    run_test("fresh", 1'b0, 32'h00000001, 13);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
